// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types for the execute-stage ALU and mult/div unit
//
// Purpose: opcode enums for the combinational ALU and the iterative
//          multiply/divide engine, plus the engine state encoding.
// Ports:   none (package).

package alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_XOR  = 3'b011,
    ALU_NOR  = 3'b100,
    ALU_SLTU = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  // Bit 1 selects divide, bit 0 selects signed operation.
  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/alu_mdu_if.sv
// rtl/alu_mdu_if.sv - operand, ALU and mult/div handshake bundle
//
// Purpose: groups every non-clock signal of alu_mdu.
// Modports:
//   master - controller side: drives operands, alu_control, md_start/md_op,
//            mt_hi/mt_lo; observes ALU result/flags, md_busy/md_done,
//            div_by_zero, hi, lo.
//   slave  - alu_mdu side (directions mirrored).

interface alu_mdu_if #(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic [2:0]            alu_control;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  zero_flag;
  logic                  ovf_flag;
  logic                  md_start;
  logic [1:0]            md_op;
  logic                  mt_hi;
  logic                  mt_lo;
  logic                  md_busy;
  logic                  md_done;
  logic                  div_by_zero;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output src_a, src_b, alu_control, md_start, md_op, mt_hi, mt_lo,
    input  alu_result, zero_flag, ovf_flag, md_busy, md_done, div_by_zero, hi, lo
  );

  modport slave (
    input  src_a, src_b, alu_control, md_start, md_op, mt_hi, mt_lo,
    output alu_result, zero_flag, ovf_flag, md_busy, md_done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/mdu_core.sv
// rtl/mdu_core.sv - iterative radix-2 multiply/divide engine
//
// Purpose: sign-magnitude shift-add multiplier and restoring divider, one
//          bit per cycle, W+1 cycles from accepted start to done.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start, op           request and operation (sampled only when idle)
//   src_a, src_b        dividend/multiplicand, divisor/multiplier
//   busy                state != IDLE
//   done, div_by_zero   registered one-cycle pulses during DONE
//   res_wr              HI/LO write strobe, high on the edge entering DONE
//   res_hi, res_lo      sign-corrected result presented with res_wr

module mdu_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  md_op_e                op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic                  res_wr,
  output logic [DATA_WIDTH-1:0] res_hi,
  output logic [DATA_WIDTH-1:0] res_lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  md_state_e     state;
  logic          is_div;
  logic [CW-1:0] cnt;
  logic          last;     // all W steps taken; next edge enters DONE
  logic [W-1:0]  opnd;     // multiplicand or divisor magnitude
  logic [2*W-1:0] acc;     // {upper, lower}: product, or {remainder, quotient}
  logic          neg_lo;   // negate product / quotient
  logic          neg_hi;   // negate remainder (dividend sign)
  logic          dbz;

  logic          a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    add_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]    div_shift, div_diff;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] prod;
  logic [W-1:0]  quo, rem;

  always_comb begin
    a_neg = op[0] & src_a[W-1];
    b_neg = op[0] & src_b[W-1];
    // The most-negative value maps to 2^(W-1), which still fits unsigned.
    a_mag = a_neg ? -src_a : src_a;
    b_mag = b_neg ? -src_b : src_b;

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    add_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
    mul_next = acc[0] ? {add_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};

    // Restoring divide: dividend bits shift from the low half into the remainder.
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_next  = div_diff[W] ? {div_shift[W-1:0], acc[W-2:0], 1'b0}
                            : {div_diff[W-1:0],  acc[W-2:0], 1'b1};

    prod = neg_lo ? -acc : acc;
    quo  = acc[W-1:0];
    rem  = acc[2*W-1:W];

    if (is_div) begin
      // A zero divisor never borrows, so the remainder path already rebuilds
      // the raw dividend; only the quotient needs forcing to all ones.
      res_lo = dbz ? {W{1'b1}} : (neg_lo ? -quo : quo);
      res_hi = neg_hi ? -rem : rem;
    end else begin
      res_hi = prod[2*W-1:W];
      res_lo = prod[W-1:0];
    end

    res_wr = (state == MD_CALC) && last;
  end

  assign busy = (state != MD_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= MD_IDLE;
      is_div      <= 1'b0;
      cnt         <= '0;
      last        <= 1'b0;
      opnd        <= '0;
      acc         <= '0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      dbz         <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start) begin
            state  <= MD_CALC;
            is_div <= op[1];
            cnt    <= CW'(W - 1);
            last   <= 1'b0;
            neg_lo <= a_neg ^ b_neg;
            if (op[1]) begin
              opnd   <= b_mag;
              acc    <= {{W{1'b0}}, a_mag};
              neg_hi <= a_neg;
              dbz    <= (src_b == '0);
            end else begin
              opnd   <= a_mag;
              acc    <= {{W{1'b0}}, b_mag};
              neg_hi <= a_neg ^ b_neg;
              dbz    <= 1'b0;
            end
          end
        end
        MD_CALC: begin
          if (last) begin
            state       <= MD_DONE;
            done        <= 1'b1;
            div_by_zero <= dbz;
          end else begin
            acc <= is_div ? div_next : mul_next;
            if (cnt == '0) last <= 1'b1;
            else           cnt  <= cnt - CW'(1);
          end
        end
        MD_DONE: state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - execute-stage ALU with HI/LO registers and mult/div unit
//
// Purpose: combinational 8-op ALU with zero/overflow flags, HI/LO registers
//          written by the mult/div engine or by MTHI/MTLO.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (clears HI/LO, aborts engine)
//   bus      alu_mdu_if.slave: operands, ALU op/result/flags, md_start/md_op,
//            mt_hi/mt_lo, md_busy/md_done/div_by_zero, hi/lo

module alu_mdu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic       clk,
  input logic       reset_n,
  alu_mdu_if.slave  bus
);

  localparam int W = DATA_WIDTH;

  logic [W-1:0] a, b, sum, diff, res;
  logic         ovf;

  always_comb begin
    a    = bus.src_a;
    b    = bus.src_b;
    sum  = a + b;
    diff = a - b;
    ovf  = 1'b0;
    case (alu_op_e'(bus.alu_control))
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_ADD: begin
        res = sum;
        ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      ALU_XOR:  res = a ^ b;
      ALU_NOR:  res = ~(a | b);
      ALU_SLTU: res = {{(W-1){1'b0}}, (a < b)};
      ALU_SUB: begin
        res = diff;
        ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      ALU_SLT:  res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      default:  res = '0;
    endcase
    bus.alu_result = res;
    bus.zero_flag  = (res == '0);
    bus.ovf_flag   = ovf;
  end

  logic         busy, res_wr;
  logic [W-1:0] res_hi, res_lo;
  logic [W-1:0] hi_q, lo_q;

  mdu_core #(.DATA_WIDTH(W)) u_core (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (bus.md_start),
    .op          (md_op_e'(bus.md_op)),
    .src_a       (bus.src_a),
    .src_b       (bus.src_b),
    .busy        (busy),
    .done        (bus.md_done),
    .div_by_zero (bus.div_by_zero),
    .res_wr      (res_wr),
    .res_hi      (res_hi),
    .res_lo      (res_lo)
  );

  // MTHI/MTLO only land when the engine is idle and no start competes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (res_wr) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (!busy && !bus.md_start) begin
      if (bus.mt_hi) hi_q <= bus.src_a;
      if (bus.mt_lo) lo_q <= bus.src_a;
    end
  end

  assign bus.md_busy = busy;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - directed self-checking bench for alu_mdu at DATA_WIDTH=8

module tb_alu_mdu;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_mdu_if #(.DATA_WIDTH(W)) bus();
  alu_mdu #(.DATA_WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, r;
    logic         z, o;
  } alu_vec_t;
  alu_vec_t av[10];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_md(input string tag, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                        input logic e_dbz, input bit interfere, input bit with_mt);
    int lat;
    int extra;
    @(negedge clk);
    bus.md_start = 1'b1; bus.md_op = op; bus.src_a = a; bus.src_b = b;
    bus.mt_hi = with_mt; bus.mt_lo = with_mt;
    lat = -1;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.md_start = 1'b0; bus.mt_hi = 1'b0; bus.mt_lo = 1'b0;
        check({tag, " busy"}, 64'(bus.md_busy), 64'd1);
      end
      if (i == 4) begin
        check({tag, " hi held"}, 64'(bus.hi), 64'(m_hi));
        check({tag, " lo held"}, 64'(bus.lo), 64'(m_lo));
      end
      if (interfere) begin
        if (i == 2) begin
          bus.md_start = 1'b1; bus.md_op = 2'b11; bus.src_a = 8'h10; bus.src_b = 8'h03;
        end
        if (i == 3) bus.md_start = 1'b0;
        if (i == 5) begin bus.mt_hi = 1'b1; bus.src_a = 8'h3C; end
        if (i == 6) begin
          bus.mt_hi = 1'b0;
          check({tag, " mt_hi busy"}, 64'(bus.hi), 64'(m_hi));
        end
      end
      if (bus.md_done) begin lat = i; break; end
    end
    check({tag, " latency"}, 64'(lat), 64'(W + 1));
    check({tag, " hi"}, 64'(bus.hi), 64'(e_hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(e_lo));
    check({tag, " dbz"}, 64'(bus.div_by_zero), 64'(e_dbz));
    m_hi = e_hi;
    m_lo = e_lo;
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.md_done) extra++;
      if (bus.div_by_zero) extra++;
    end
    check({tag, " extra pulses"}, 64'(extra), 64'd0);
  endtask

  initial begin
    int ndone;
    bus.src_a = '0; bus.src_b = '0; bus.alu_control = 3'b000;
    bus.md_start = 1'b0; bus.md_op = 2'b00; bus.mt_hi = 1'b0; bus.mt_lo = 1'b0;

    repeat (2) @(negedge clk);
    check("rst hi",   64'(bus.hi), 64'd0);
    check("rst lo",   64'(bus.lo), 64'd0);
    check("rst busy", 64'(bus.md_busy), 64'd0);
    check("rst done", 64'(bus.md_done), 64'd0);
    check("rst dbz",  64'(bus.div_by_zero), 64'd0);
    reset_n = 1'b1;

    av[0] = '{3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};  // ADD overflow
    av[1] = '{3'b110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};  // SUB zero
    av[2] = '{3'b111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0};  // SLT
    av[3] = '{3'b101, 8'h80, 8'h01, 8'h00, 1'b1, 1'b0};  // SLTU
    av[4] = '{3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};  // AND
    av[5] = '{3'b001, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};  // OR
    av[6] = '{3'b011, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0};  // XOR
    av[7] = '{3'b100, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};  // NOR
    av[8] = '{3'b110, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};  // SUB overflow
    av[9] = '{3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};  // ADD wrap, no ovf
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.alu_control = av[i].op; bus.src_a = av[i].a; bus.src_b = av[i].b;
      #1;
      check($sformatf("alu%0d result", i), 64'(bus.alu_result), 64'(av[i].r));
      check($sformatf("alu%0d zero", i),   64'(bus.zero_flag),  64'(av[i].z));
      check($sformatf("alu%0d ovf", i),    64'(bus.ovf_flag),   64'(av[i].o));
    end

    run_md("mult fd*05",  2'b01, 8'hFD, 8'h05, 8'hFF, 8'hF1, 1'b0, 1'b0, 1'b0);
    run_md("multu ff*ff", 2'b00, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0, 1'b0, 1'b0);
    run_md("div f9/02",   2'b11, 8'hF9, 8'h02, 8'hFF, 8'hFD, 1'b0, 1'b0, 1'b0);
    run_md("div 80/ff",   2'b11, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0);
    run_md("divu 07/00",  2'b10, 8'h07, 8'h00, 8'h07, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_md("div f9/00",   2'b11, 8'hF9, 8'h00, 8'hF9, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_md("divu c8/07",  2'b10, 8'hC8, 8'h07, 8'h04, 8'h1C, 1'b0, 1'b0, 1'b0);
    run_md("div 07/fe",   2'b11, 8'h07, 8'hFE, 8'h01, 8'hFD, 1'b0, 1'b0, 1'b0);
    run_md("mult 7f*80",  2'b01, 8'h7F, 8'h80, 8'hC0, 8'h80, 1'b0, 1'b0, 1'b0);
    run_md("multu busy",  2'b00, 8'h03, 8'h04, 8'h00, 8'h0C, 1'b0, 1'b1, 1'b0);
    run_md("start+mt",    2'b00, 8'h02, 8'h03, 8'h00, 8'h06, 1'b0, 1'b0, 1'b1);

    @(negedge clk);
    bus.mt_lo = 1'b1; bus.src_a = 8'hA5;
    @(negedge clk);
    bus.mt_lo = 1'b0;
    check("mtlo lo", 64'(bus.lo), 64'hA5);
    check("mtlo hi", 64'(bus.hi), 64'(m_hi));
    bus.mt_hi = 1'b1; bus.mt_lo = 1'b1; bus.src_a = 8'h5A;
    @(negedge clk);
    bus.mt_hi = 1'b0; bus.mt_lo = 1'b0;
    check("mt both hi", 64'(bus.hi), 64'h5A);
    check("mt both lo", 64'(bus.lo), 64'h5A);
    m_hi = 8'h5A; m_lo = 8'h5A;

    bus.md_start = 1'b1; bus.md_op = 2'b01; bus.src_a = 8'h7F; bus.src_b = 8'h03;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) bus.md_start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check("abort hi",   64'(bus.hi), 64'd0);
    check("abort lo",   64'(bus.lo), 64'd0);
    check("abort busy", 64'(bus.md_busy), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.md_done) ndone++;
    end
    check("abort no done", 64'(ndone), 64'd0);
    run_md("mult after rst", 2'b01, 8'h7F, 8'h03, 8'h01, 8'h7D, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor to the single-cycle datapath ALU for the MIPS core.
- Keeps the combinational ALU path: 8 ops, plus zero and signed-overflow flags.
- Adds an iterative multiply/divide unit (MULT, MULTU, DIV, DIVU) that writes HI/LO registers through a start/busy/done handshake.
- Sits in the execute stage; the controller stalls on md_busy.

Parameters:
DATA_WIDTH, 32, operand/result/HI/LO width; legal range 4..64.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
src_a  input  DATA_WIDTH  operand A (rs); dividend/multiplicand; MTHI/MTLO data
src_b  input  DATA_WIDTH  operand B (rt); divisor/multiplier
alu_control  input  3  combinational ALU op select
alu_result  output  DATA_WIDTH  combinational ALU result
zero_flag  output  1  alu_result == 0
ovf_flag  output  1  signed overflow for ADD/SUB; 0 for all other ops
md_start  input  1  request a mult/div op
md_op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
mt_hi  input  1  write src_a into HI
mt_lo  input  1  write src_a into LO
md_busy  output  1  engine occupied
md_done  output  1  one-cycle pulse; HI/LO hold the new result
div_by_zero  output  1  pulses with md_done when a divide had src_b == 0
hi  output  DATA_WIDTH  HI register
lo  output  DATA_WIDTH  LO register

Behaviour:
- ALU (combinational, no clock, unaffected by engine state):
  - 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SLTU, 110 SUB, 111 SLT.
  - ADD/SUB wrap modulo 2^W.
  - SLT/SLTU produce 0 or 1, zero-extended.
- Reset (async assert, sync release):
  - State IDLE; hi=0, lo=0, md_busy=0, md_done=0, div_by_zero=0.
  - Asserting reset mid-operation aborts it: no md_done, HI/LO cleared.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - md_start=1 on edge k latches operands and md_op, goes to CALC with counter = W-1.
  - Signed ops latch operand magnitudes and record result signs.
- CALC:
  - One radix-2 step per cycle: shift-add for multiply, restoring subtract for divide.
  - Counter decrements; when it reaches 0, the next edge goes to DONE.
- DONE:
  - Lasts exactly one cycle, entered at edge k+W+1.
  - HI/LO are updated on entry; md_done=1 during this cycle; then back to IDLE.
  - Latency from start to md_done is W+1 cycles. Back-to-back start is accepted from IDLE only, one cycle after DONE.
- md_busy = (state != IDLE). md_start while busy is ignored. md_op is sampled only with an accepted start.
- Multiply result: 2W-bit product; HI = upper W bits, LO = lower W bits. MULT result is two's-complement.
- Divide result: LO = quotient, HI = remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - Most-negative / -1: LO = most-negative value, HI = 0, no flag.
  - Divisor 0: LO = all ones, HI = dividend (raw src_a), div_by_zero=1 with md_done. Still takes W+1 cycles.
- MTHI/MTLO:
  - Write src_a on the clock edge, only in IDLE with md_start=0; ignored otherwise.
  - mt_hi and mt_lo together write both registers.
  - md_start together with mt_* in IDLE: start wins, mt_* dropped.
- HI/LO hold their value in all other cycles, including during CALC; old values stay readable until DONE.

Decomposition:
- Package alu_pkg:
  - alu_op_e (3-bit enum of the 8 ALU codes).
  - md_op_e (MULTU/MULT/DIVU/DIV).
  - md_state_e (IDLE/CALC/DONE).
- Sub-module mdu_core: the iterative engine (FSM, counter, accumulator/remainder registers, sign fix-up).
- alu_mdu contains the combinational ALU, the HI/LO registers and the mt_* write logic.

Test Plan (DATA_WIDTH=8):
- ALU flags: ADD 7F+01 -> alu_result 80, ovf_flag=1, zero_flag=0. SUB 05-05 -> 00, zero_flag=1, ovf_flag=0. SLT 80,01 -> 01. SLTU 80,01 -> 00.
- MULT and MULTU:
  - MULT FD*05 (-3*5) with start at edge k -> md_busy from k+1; md_done=1 in the cycle after edge k+9; hi=FF, lo=F1.
  - MULTU FF*FF -> hi=FE, lo=01.
- Signed DIV:
  - F9/02 (-7/2) -> lo=FD, hi=FF.
  - 80/FF -> lo=80, hi=00, div_by_zero=0.
- Divide by zero: DIVU 07/00 -> lo=FF, hi=07, div_by_zero=1 only in the md_done cycle; latency still 9 cycles.
- Handshake and MT writes:
  - Second md_start with a different op during CALC -> ignored; one md_done only, first result.
  - mt_hi with src_a=3C while busy -> HI unchanged.
  - mt_lo in IDLE with src_a=A5 -> lo=A5 next cycle.
- Reset mid-op: start MULT, drop reset_n at cycle 4 -> hi=lo=00 and md_busy=0 immediately; no md_done after release; a new start completes normally.
